multi_alarm_clock: RTL
======================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock cycles per 1 s tick.
REQ-002 SHALL have parameter NUM_ALM, default 4, number of alarm slots (1..16).
REQ-003 SHALL have parameter RING_SEC, default 30, ring seconds before auto-silence.
REQ-004 SHALL have parameter SNOOZE_SEC, default 300, snooze length in seconds.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have the following ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- set_en  in  1  set mode; freezes timekeeping
- set_wr  in  1  write strobe for set_val
- set_sel  in  2  field select: 0 hh, 1 mm, 2 ss
- set_val  in  6  binary field value
- alm_wr  in  1  alarm slot write strobe
- alm_idx  in  4  alarm slot index; also selects the slot shown in display mode 2
- alm_on  in  1  enable bit written to the slot
- alm_hh  in  5  alarm hours, binary
- alm_mm  in  6  alarm minutes, binary
- ack  in  1  silence alarm; clear timer done
- snooze  in  1  snooze request
- tmr_load  in  1  load countdown timer
- tmr_val  in  17  countdown value, seconds
- tmr_run  in  1  timer run enable, level-sensitive
- disp_mode  in  2  display source select
- tick  out  1  one-cycle 1 Hz pulse
- hh  out  5  hours
- mm  out  6  minutes
- ss  out  6  seconds
- alm_hit  out  NUM_ALM  sticky per-slot match flags
- buzz  out  1  buzzer drive
- tmr_done  out  1  sticky timer-expired flag
- disp  out  16  four BCD digits; [15:12] is the most significant

Function
REQ-007 SHALL run a divider counting 0..CLK_HZ-1 and pulse tick for one cycle when the count equals CLK_HZ-1, then wrap the count to 0.
REQ-008 SHALL hold the divider at 0 and suppress tick while set_en=1, so the first tick comes CLK_HZ cycles after set_en falls.
REQ-009 SHALL advance time on each tick: ss 59->0 carries into mm, mm 59->0 carries into hh, hh 23->0 wraps.
REQ-010 SHALL write set_val into the field chosen by set_sel when set_wr=1 and set_en=1.
REQ-011 SHALL ignore that write if the value is out of range (hh>23, mm/ss>59) or set_sel=3.
REQ-012 SHALL write {alm_on, alm_hh, alm_mm} into slot alm_idx when alm_wr=1, ignoring the write if alm_idx>=NUM_ALM, alm_hh>23 or alm_mm>59.
REQ-013 SHALL detect a match on the tick that sets ss to 0 when the new hh:mm equals an enabled slot; each matching slot sets its alm_hit bit.
REQ-014 SHALL implement the ring FSM with states IDLE, RING and SNOOZE; buzz=1 only in RING.
REQ-015 IDLE SHALL go to RING on any match and load the ring counter with RING_SEC.
REQ-016 RING SHALL go to IDLE on ack and clear alm_hit.
REQ-017 RING SHALL go to SNOOZE on snooze and load the snooze counter with SNOOZE_SEC.
REQ-018 RING SHALL go to IDLE after RING_SEC ticks without ack and clear alm_hit.
REQ-019 SNOOZE SHALL go to RING when the snooze counter reaches 0 (ring counter reloaded), and SHALL go to IDLE on ack.
REQ-020 A match while in RING or SNOOZE SHALL OR the new bits into alm_hit, enter RING and reload the ring counter.
REQ-021 SHALL resolve simultaneous events as follows: match beats ack and snooze; when both occur, alm_hit holds only the new bits; ack beats snooze.
REQ-022 SHALL load tmr_val into the timer on tmr_load, clearing tmr_done; tmr_load beats a decrement in the same cycle.
REQ-023 SHALL decrement the timer on a tick while tmr_run=1 and the count is nonzero.
REQ-024 SHALL set tmr_done on the 1->0 transition of the timer and clear it on ack or tmr_load; loading 0 SHALL NOT set tmr_done.
REQ-025 SHALL drive buzz as (FSM in RING) OR tmr_done.
REQ-026 SHALL register disp with one cycle of latency according to disp_mode:
- 0: hh, mm
- 1: mm, ss
- 2: slot alm_idx hh, mm (0000 if alm_idx is out of range)
- 3: timer remaining as minutes (saturated at 99), seconds
REQ-027 SHALL keep hh/mm/ss and alm_hit as registered outputs with no combinational path from the inputs.

Reset
REQ-028 On rst=1 at a clk edge, the block SHALL clear the divider, time (00:00:00), all slots (disabled, 00:00), alm_hit and the timer, set the FSM to IDLE, and drive tick=0, buzz=0, tmr_done=0, disp=0.
REQ-029 rst SHALL take priority over every other input, including in the middle of RING or SNOOZE.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, RING, SNOOZE), the field-select codes, the display-mode codes, and the constants 23 and 59.
REQ-031 The 1 Hz divider SHALL be the sub-module tick_divider, parameterised by CLK_HZ, with inputs clk, rst and hold and output tick.

Verification (bench CLK_HZ=4, RING_SEC=3, SNOOZE_SEC=2)
REQ-032 Set 23:59:58, run 2 ticks -> 00:00:00; disp in mode 0 is 0x0000.
REQ-033 Slot 1 = 07:30 enabled, time 07:29:59, 1 tick -> alm_hit=0b0010, buzz=1; 3 more ticks with no ack -> buzz=0, alm_hit=0.
REQ-034 During RING assert snooze -> buzz=0; 2 ticks -> buzz=1; ack -> IDLE, alm_hit=0.
REQ-035 set_wr with set_sel=0, set_val=24 -> hh unchanged; set_en held 10 cycles -> no tick, ss frozen.
REQ-036 tmr_val=2 with tmr_run=1 -> tmr_done after 2 ticks, buzz=1; ack -> tmr_done=0; tmr_val=0 -> tmr_done stays 0.
REQ-037 Assert rst while in RING -> next cycle buzz=0, time 00:00:00, slots disabled.

Source files
------------

// File: rtl/multi_alarm_clock_pkg.sv
// Shared definitions for the multi-alarm clock: ring FSM states, select codes,
// time-field limits and a two-digit BCD helper.
package multi_alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } ring_state_e;

  localparam logic [1:0] SEL_HH = 2'd0;
  localparam logic [1:0] SEL_MM = 2'd1;
  localparam logic [1:0] SEL_SS = 2'd2;

  localparam logic [1:0] DISP_HHMM  = 2'd0;
  localparam logic [1:0] DISP_MMSS  = 2'd1;
  localparam logic [1:0] DISP_ALARM = 2'd2;
  localparam logic [1:0] DISP_TIMER = 2'd3;

  localparam logic [4:0] MAX_HH = 5'd23;
  localparam logic [5:0] MAX_MS = 6'd59;

  // Values above 99 are the caller's responsibility to saturate first.
  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/multi_alarm_clock_tick_divider.sv
// Free-running 1 Hz tick generator; hold parks the count at zero so the next
// tick lands a full period after hold is released.
module tick_divider #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// Time-of-day clock with NUM_ALM alarm slots, ring/snooze FSM, a countdown
// timer and a registered four-digit BCD display.
module multi_alarm_clock
  import multi_alarm_clock_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int NUM_ALM    = 4,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic               set_wr,
  input  logic [1:0]         set_sel,
  input  logic [5:0]         set_val,
  input  logic               alm_wr,
  input  logic [3:0]         alm_idx,
  input  logic               alm_on,
  input  logic [4:0]         alm_hh,
  input  logic [5:0]         alm_mm,
  input  logic               ack,
  input  logic               snooze,
  input  logic               tmr_load,
  input  logic [16:0]        tmr_val,
  input  logic               tmr_run,
  input  logic [1:0]         disp_mode,
  output logic               tick,
  output logic [4:0]         hh,
  output logic [5:0]         mm,
  output logic [5:0]         ss,
  output logic [NUM_ALM-1:0] alm_hit,
  output logic               buzz,
  output logic               tmr_done,
  output logic [15:0]        disp
);

  localparam int RCW = (RING_SEC > 0) ? $clog2(RING_SEC + 1) : 1;
  localparam int SCW = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
  localparam logic [RCW-1:0] RING_LD = RCW'(RING_SEC);
  localparam logic [SCW-1:0] SNZ_LD  = SCW'(SNOOZE_SEC);

  logic tick_w;
  logic adv;

  logic [4:0] hh_q, hh_d;
  logic [5:0] mm_q, mm_d;
  logic [5:0] ss_q, ss_d;
  logic       roll_min;

  // Slot storage is sized for the full 4-bit index so alm_idx never selects
  // past the array; entries at or above NUM_ALM are never written.
  logic       alm_en_q [16];
  logic [4:0] alm_hh_q [16];
  logic [5:0] alm_mm_q [16];
  logic       alm_idx_ok;

  logic [NUM_ALM-1:0] match_vec;
  logic [NUM_ALM-1:0] alm_hit_q, hit_d;
  ring_state_e        state_q, state_d;
  logic [RCW-1:0]     ring_q, ring_d;
  logic [SCW-1:0]     snz_q, snz_d;

  logic [16:0] tmr_q, tmr_d;
  logic        tmr_done_q, done_d;
  logic [16:0] tmr_min;
  logic [6:0]  tmr_min_sat;
  logic [5:0]  tmr_sec;
  logic [15:0] disp_q, disp_d;

  tick_divider #(
    .CLK_HZ(CLK_HZ)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .hold(set_en),
    .tick(tick_w)
  );

  // A tick already in flight when set_en rises must not move the time.
  assign adv        = tick_w & ~set_en;
  assign roll_min   = adv && (ss_q == MAX_MS);
  assign alm_idx_ok = ({1'b0, alm_idx} < 5'(NUM_ALM));

  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (adv) begin
      if (ss_q == MAX_MS) begin
        ss_d = '0;
        if (mm_q == MAX_MS) begin
          mm_d = '0;
          hh_d = (hh_q == MAX_HH) ? 5'd0 : hh_q + 5'd1;
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end else if (set_en && set_wr) begin
      unique case (set_sel)
        SEL_HH:  if (set_val <= {1'b0, MAX_HH}) hh_d = set_val[4:0];
        SEL_MM:  if (set_val <= MAX_MS) mm_d = set_val;
        SEL_SS:  if (set_val <= MAX_MS) ss_d = set_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hh_q <= '0;
      mm_q <= '0;
      ss_q <= '0;
    end else begin
      hh_q <= hh_d;
      mm_q <= mm_d;
      ss_q <= ss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        alm_en_q[i] <= 1'b0;
        alm_hh_q[i] <= '0;
        alm_mm_q[i] <= '0;
      end
    end else if (alm_wr && alm_idx_ok && (alm_hh <= MAX_HH) && (alm_mm <= MAX_MS)) begin
      alm_en_q[alm_idx] <= alm_on;
      alm_hh_q[alm_idx] <= alm_hh;
      alm_mm_q[alm_idx] <= alm_mm;
    end
  end

  // Compare against the time being entered, not the time being left.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_ALM; i++) begin
      match_vec[i] = roll_min && alm_en_q[i] &&
                     (alm_hh_q[i] == hh_d) && (alm_mm_q[i] == mm_d);
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    hit_d   = alm_hit_q;
    if (|match_vec) begin
      state_d = ST_RING;
      ring_d  = RING_LD;
      hit_d   = (ack ? '0 : alm_hit_q) | match_vec;
    end else begin
      unique case (state_q)
        ST_RING: begin
          if (ack) begin
            state_d = ST_IDLE;
            hit_d   = '0;
          end else if (snooze) begin
            state_d = ST_SNOOZE;
            snz_d   = SNZ_LD;
          end else if (adv) begin
            if (ring_q <= RCW'(1)) begin
              state_d = ST_IDLE;
              hit_d   = '0;
            end else begin
              ring_d = ring_q - RCW'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (ack) begin
            state_d = ST_IDLE;
            hit_d   = '0;
          end else if (adv) begin
            if (snz_q <= SCW'(1)) begin
              state_d = ST_RING;
              ring_d  = RING_LD;
            end else begin
              snz_d = snz_q - SCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ring_q    <= '0;
      snz_q     <= '0;
      alm_hit_q <= '0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      snz_q     <= snz_d;
      alm_hit_q <= hit_d;
    end
  end

  // Loading always wins; done fires only on a real 1->0 countdown step.
  always_comb begin
    tmr_d  = tmr_q;
    done_d = tmr_done_q;
    if (tmr_load) begin
      tmr_d  = tmr_val;
      done_d = 1'b0;
    end else begin
      if (ack) done_d = 1'b0;
      if (adv && tmr_run && (tmr_q != '0)) begin
        tmr_d = tmr_q - 17'd1;
        if (tmr_q == 17'd1) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q      <= '0;
      tmr_done_q <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      tmr_done_q <= done_d;
    end
  end

  assign tmr_min     = tmr_q / 17'd60;
  assign tmr_sec     = 6'(tmr_q % 17'd60);
  assign tmr_min_sat = (tmr_min > 17'd99) ? 7'd99 : tmr_min[6:0];

  always_comb begin
    disp_d = '0;
    unique case (disp_mode)
      DISP_HHMM: disp_d = {to_bcd2({2'b0, hh_q}), to_bcd2({1'b0, mm_q})};
      DISP_MMSS: disp_d = {to_bcd2({1'b0, mm_q}), to_bcd2({1'b0, ss_q})};
      DISP_ALARM: begin
        if (alm_idx_ok)
          disp_d = {to_bcd2({2'b0, alm_hh_q[alm_idx]}), to_bcd2({1'b0, alm_mm_q[alm_idx]})};
      end
      DISP_TIMER: disp_d = {to_bcd2(tmr_min_sat), to_bcd2({1'b0, tmr_sec})};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) disp_q <= '0;
    else     disp_q <= disp_d;
  end

  assign tick     = tick_w;
  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign alm_hit  = alm_hit_q;
  assign buzz     = (state_q == ST_RING) | tmr_done_q;
  assign tmr_done = tmr_done_q;
  assign disp     = disp_q;

endmodule
